// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encodings, R/W flag values
// and the frame-length helper.
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_len(input int a, input int d);
    return a + 1 + d;
  endfunction

endpackage

// File: rtl/spi_sclk_tick.sv
// SCLK half-period timer: a one-cycle tick every DIV clocks, realigned by load
// so the first tick lands exactly DIV cycles after the load cycle.
module spi_sclk_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic load,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (load || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-CS SPI master (SCLK idle low, LSB first): one register read/write
// request becomes one frame of {data, addr, rw}, read data returned on RSP_VALID.
module spi_master
  import spi_pkg::*;
#(
  parameter int D   = 8,
  parameter int A   = 8,
  parameter int DIV = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ_VALID,
  output logic         REQ_READY,
  input  logic         REQ_WR,
  input  logic [A-1:0] REQ_ADDR,
  input  logic [D-1:0] REQ_WDATA,
  output logic         RSP_VALID,
  output logic [D-1:0] RSP_RDATA,
  output logic         BUSY,
  output logic         SS,
  output logic         SCLK,
  output logic         MOSI,
  input  logic         MISO
);

  localparam int N  = frame_len(A, D);
  localparam int EW = $clog2(2 * N + 1);
  // edge_q holds 2k+1 while SCLK is high for bit k
  localparam logic [EW-1:0] EDGE_DATA0 = EW'(2 * A + 3);
  localparam logic [EW-1:0] EDGE_LAST  = EW'(2 * N - 1);

  logic [2:0]    state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [D-1:0]  cap_q, cap_d;
  logic [D-1:0]  rdata_q, rdata_d;
  logic [EW-1:0] edge_q, edge_d;
  logic          wr_q, wr_d;
  logic          ss_q, ss_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          gap_half_q, gap_half_d;
  logic          tick;
  logic          load;

  spi_sclk_tick #(.DIV(DIV)) u_tick (
    .clk  (CLK),
    .srst (RST),
    .load (load),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cap_d       = cap_q;
    rdata_d     = rdata_q;
    edge_d      = edge_q;
    wr_d        = wr_q;
    ss_d        = ss_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    gap_half_d  = gap_half_q;
    rsp_valid_d = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          // Read frames carry zeros in the data field so MOSI idles low there
          shreg_d = {((REQ_WR == RW_WRITE) ? REQ_WDATA : {D{1'b0}}), REQ_ADDR, REQ_WR};
          wr_d    = REQ_WR;
          ss_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = REQ_WR;
          cap_d   = '0;
          edge_d  = '0;
          load    = 1'b1;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          edge_d  = edge_q + EW'(1);
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          edge_d = edge_q + EW'(1);
          if (sclk_q) begin
            sclk_d  = 1'b0;
            shreg_d = shreg_q >> 1;
            mosi_d  = shreg_q[1];
            // LSB arrives first, so shifting in from the top leaves it at bit 0
            if ((wr_q == RW_READ) && (edge_q >= EDGE_DATA0)) begin
              cap_d = {MISO, cap_q[D-1:1]};
            end
            if (edge_q == EDGE_LAST) begin
              state_d = ST_HOLD;
            end
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          ss_d        = 1'b1;
          rsp_valid_d = 1'b1;
          rdata_d     = (wr_q == RW_WRITE) ? '0 : cap_q;
          gap_half_d  = 1'b0;
          state_d     = ST_GAP;
        end
      end

      ST_GAP: begin
        if (tick) begin
          if (gap_half_q) begin
            state_d = ST_IDLE;
          end else begin
            gap_half_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        ss_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cap_q       <= '0;
      rdata_q     <= '0;
      edge_q      <= '0;
      wr_q        <= 1'b0;
      ss_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      gap_half_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cap_q       <= cap_d;
      rdata_q     <= rdata_d;
      edge_q      <= edge_d;
      wr_q        <= wr_d;
      ss_q        <= ss_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      gap_half_q  <= gap_half_d;
    end
  end

  assign REQ_READY = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rdata_q;
  assign SS        = ss_q;
  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;

endmodule
